// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and its decoder:
// FSM state encoding, default widths and control-priority selection.
package pc_sequencer_pkg;

  localparam int PC_ADDR_W = 8;
  localparam int PC_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Listed highest priority first.
  typedef enum logic [2:0] {
    CTL_HALT = 3'd0,
    CTL_RET  = 3'd1,
    CTL_CALL = 3'd2,
    CTL_JUMP = 3'd3,
    CTL_SEQ  = 3'd4
  } ctl_t;

  function automatic ctl_t ctl_sel(input logic halt, input logic ret,
                                   input logic call, input logic jump);
    if (halt)      return CTL_HALT;
    else if (ret)  return CTL_RET;
    else if (call) return CTL_CALL;
    else if (jump) return CTL_JUMP;
    else           return CTL_SEQ;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake with program memory plus the decoder control/result bundle.
interface pc_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              exec_done;
  logic              jump;
  logic              call;
  logic              ret;
  logic              halt;
  logic [ADDR_W-1:0] target;

  modport master (
    output mem_req, mem_addr, instr, instr_valid,
    input  mem_ack, mem_data, exec_done, jump, call, ret, halt, target
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid,
    output mem_ack, mem_data, exec_done, jump, call, ret, halt, target
  );
endinterface

// File: rtl/pc_sequencer_inc.sv
// PC increment datapath: modulo 2^W, wraps silently at the top of the address space.
module pc_sequencer_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = a + W'(1);
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: fetch/decode/execute sequencing, jump, call/return and halt.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | mem_req high at pc, waiting for mem_ack
// DECODE | instr latched, instr_valid pulse
// EXEC   | waiting for exec_done, then apply control
// HALT   | stopped (halt or stack error), waiting for start
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = PC_ADDR_W,
  parameter int DATA_W      = PC_DATA_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  pc_sequencer_if.master    bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              stack_empty, stack_full;
  logic              push, pop, err_set, restart, load_instr;

  pc_sequencer_inc #(.W(ADDR_W)) u_inc (
    .a (pc),
    .y (pc_inc)
  );

  assign wr_idx      = sp[IDX_W-1:0];
  assign rd_idx      = wr_idx - IDX_W'(1);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));

  // Outputs decode directly from state so an async reset drops mem_req immediately.
  assign bus.mem_req     = (state == ST_FETCH);
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = (state == ST_DECODE);
  assign bus.instr       = instr_q;
  assign halted          = (state == ST_HALT);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    restart    = 1'b0;
    load_instr = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_nxt    = start_addr;
          restart   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ack) begin
          load_instr = 1'b1;
          state_nxt  = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
          case (ctl_sel(bus.halt, bus.ret, bus.call, bus.jump))
            CTL_HALT: begin
              pc_nxt    = pc_inc;
              state_nxt = ST_HALT;
            end
            CTL_RET: begin
              if (stack_empty) begin
                err_set   = 1'b1;
                state_nxt = ST_HALT;
              end else begin
                pop       = 1'b1;
                pc_nxt    = stack_mem[rd_idx];
                state_nxt = ST_FETCH;
              end
            end
            CTL_CALL: begin
              if (stack_full) begin
                err_set   = 1'b1;
                state_nxt = ST_HALT;
              end else begin
                push      = 1'b1;
                pc_nxt    = bus.target;
                state_nxt = ST_FETCH;
              end
            end
            CTL_JUMP: begin
              pc_nxt    = bus.target;
              state_nxt = ST_FETCH;
            end
            default: begin
              pc_nxt    = pc_inc;
              state_nxt = ST_FETCH;
            end
          endcase
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= '0;
      instr_q   <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load_instr) instr_q <= bus.mem_data;
      if (restart) begin
        sp        <= '0;
        stack_err <= 1'b0;
      end else begin
        if (push)         sp <= sp + SP_W'(1);
        else if (pop)     sp <= sp - SP_W'(1);
        if (err_set)      stack_err <= 1'b1;
      end
    end
  end

  // Entries above sp are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential wrap, call/return, stack errors, halt, wait states.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] pc;
  logic       halted;
  logic       stack_err;
  int         checks = 0;
  int         failures = 0;

  pc_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  pc_sequencer #(.ADDR_W(8), .DATA_W(16), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .pc         (pc),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start         = 1'b0;
    start_addr    = 8'h00;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = 16'h0000;
    bus.exec_done = 1'b0;
    bus.jump      = 1'b0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.halt      = 1'b0;
    bus.target    = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_start(input logic [7:0] addr);
    start      = 1'b1;
    start_addr = addr;
    step();
    start = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr || halted !== 1'b0) begin
      failures++;
      $display("FAIL start: mem_req=%b mem_addr=%h halted=%b, required 1 %h 0",
               bus.mem_req, bus.mem_addr, halted, addr);
    end
  endtask

  // Complete one fetch at addr, with optional wait states and an ignored start.
  task automatic fetch_one(input logic [7:0] addr, input logic [15:0] data,
                           input int waits, input logic poke_start);
    for (int i = 0; i < waits; i++) begin
      if (poke_start && i == 1) begin
        start      = 1'b1;
        start_addr = 8'h99;
      end
      step();
      start = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr || pc !== addr) begin
        failures++;
        $display("FAIL fetch_wait[%0d]: mem_req=%b mem_addr=%h pc=%h, required 1 %h %h",
                 i, bus.mem_req, bus.mem_addr, pc, addr, addr);
      end
    end
    bus.mem_ack  = 1'b1;
    bus.mem_data = data;
    step();
    bus.mem_ack  = 1'b0;
    bus.mem_data = 16'hDEAD;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL decode@%h: instr_valid=%b instr=%h mem_req=%b, required 1 %h 0",
               addr, bus.instr_valid, bus.instr, bus.mem_req, data);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.instr !== data) begin
      failures++;
      $display("FAIL exec_entry@%h: instr_valid=%b mem_req=%b instr=%h, required 0 0 %h",
               addr, bus.instr_valid, bus.mem_req, bus.instr, data);
    end
  endtask

  task automatic do_exec(input logic j, input logic c, input logic r, input logic h,
                         input logic [7:0] tgt, input logic [7:0] exp_pc,
                         input logic exp_req, input logic exp_halt, input logic exp_err,
                         input string name);
    bus.exec_done = 1'b1;
    bus.jump      = j;
    bus.call      = c;
    bus.ret       = r;
    bus.halt      = h;
    bus.target    = tgt;
    step();
    bus.exec_done = 1'b0;
    bus.jump      = 1'b0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.halt      = 1'b0;
    checks++;
    if (pc !== exp_pc || bus.mem_req !== exp_req || halted !== exp_halt ||
        stack_err !== exp_err || (exp_req && bus.mem_addr !== exp_pc)) begin
      failures++;
      $display("FAIL %s: pc=%h mem_req=%b mem_addr=%h halted=%b stack_err=%b, required %h %b %h %b %b",
               name, pc, bus.mem_req, bus.mem_addr, halted, stack_err,
               exp_pc, exp_req, exp_pc, exp_halt, exp_err);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 8'h00 || pc !== 8'h00 || bus.instr !== 16'h0 ||
        bus.instr_valid !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: req=%b addr=%h pc=%h instr=%h iv=%b halted=%b err=%b, required all 0",
               bus.mem_req, bus.mem_addr, pc, bus.instr, bus.instr_valid, halted, stack_err);
    end
    step();
    rst_n = 1'b1;
    step();
    do_start(8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || pc !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_fetch: mem_req=%b pc=%h, required 0 00", bus.mem_req, pc);
    end
    #1;
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_req !== 1'b0 || halted !== 1'b0 || pc !== 8'h00) begin
      failures++;
      $display("FAIL reset_release_idle: mem_req=%b halted=%b pc=%h, required 0 0 00",
               bus.mem_req, halted, pc);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] a;
    do_reset();
    do_start(8'hFE);
    a = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      fetch_one(a, 16'hA000 + 16'(i), 0, 1'b0);
      a = a + 8'h01;
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a, 1'b1, 1'b0, 1'b0, "seq_wrap");
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_start(8'h20);
    fetch_one(8'h20, 16'h1111, 0, 1'b0);
    do_exec(1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, "call_over_jump");
    fetch_one(8'h80, 16'h2222, 0, 1'b0);
    do_exec(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h21, 1'b1, 1'b0, 1'b0, "ret_to_21");
    fetch_one(8'h21, 16'h3333, 0, 1'b0);
    do_exec(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h21, 1'b0, 1'b1, 1'b1, "ret_underflow");
  endtask

  task automatic test_overflow();
    logic [7:0] tgts [5];
    logic [7:0] cur;
    tgts = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h90};
    do_reset();
    do_start(8'h00);
    cur = 8'h00;
    for (int i = 0; i < 4; i++) begin
      fetch_one(cur, 16'h4000 + 16'(i), 0, 1'b0);
      do_exec(1'b0, 1'b1, 1'b0, 1'b0, tgts[i], tgts[i], 1'b1, 1'b0, 1'b0, "nested_call");
      cur = tgts[i];
    end
    fetch_one(cur, 16'h4444, 0, 1'b0);
    do_exec(1'b0, 1'b1, 1'b0, 1'b0, tgts[4], 8'h70, 1'b0, 1'b1, 1'b1, "call_overflow");
    step();
    checks++;
    if (bus.mem_req !== 1'b0 || halted !== 1'b1 || stack_err !== 1'b1) begin
      failures++;
      $display("FAIL overflow_hold: mem_req=%b halted=%b err=%b, required 0 1 1",
               bus.mem_req, halted, stack_err);
    end
    do_start(8'h00);
    checks++;
    if (stack_err !== 1'b0) begin
      failures++;
      $display("FAIL restart_clears_err: stack_err=%b, required 0", stack_err);
    end
    fetch_one(8'h00, 16'h5555, 0, 1'b0);
    do_exec(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "restart_stack_empty");
  endtask

  task automatic test_halt_prio();
    do_reset();
    do_start(8'h30);
    fetch_one(8'h30, 16'h6666, 0, 1'b0);
    do_exec(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 8'h31, 1'b0, 1'b1, 1'b0, "halt_over_jump");
    bus.exec_done = 1'b1;
    bus.jump      = 1'b1;
    bus.target    = 8'h77;
    step();
    step();
    bus.exec_done = 1'b0;
    bus.jump      = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h31) begin
      failures++;
      $display("FAIL halt_hold: mem_req=%b halted=%b pc=%h, required 0 1 31",
               bus.mem_req, halted, pc);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    do_start(8'h42);
    fetch_one(8'h42, 16'h7777, 5, 1'b1);
    bus.mem_ack  = 1'b1;
    bus.mem_data = 16'hBEEF;
    step();
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.instr !== 16'h7777 || bus.instr_valid !== 1'b0 || pc !== 8'h42) begin
      failures++;
      $display("FAIL ack_in_exec: mem_req=%b instr=%h iv=%b pc=%h, required 0 7777 0 42",
               bus.mem_req, bus.instr, bus.instr_valid, pc);
    end
    do_exec(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h43, 1'b1, 1'b0, 1'b0, "exec_after_waits");
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_call_ret();
    test_overflow();
    test_halt_prio();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
